// File: rtl/cdr_loop_filter_pkg.sv
// Shared definitions for the CDR loop filter and the delay-line controller it drives.
package cdr_loop_filter_pkg;

  localparam int TAP_CNT      = 16;
  localparam int TAP_W        = 4;
  localparam int DEF_THRESH   = 8;
  localparam int DEF_HOLDOFF  = 16;
  localparam int DEF_LOCK_CYC = 256;
  localparam int DEF_LOCK_W   = 9;

  typedef enum logic {
    ST_TRACK = 1'b0,
    ST_HOLD  = 1'b1
  } cdr_state_e;

endpackage

// File: rtl/cdr_lock_detect.sv
// Saturating quiet-cycle counter; locked is high while the count sits at LOCK_CYC.
module cdr_lock_detect #(
  parameter int LOCK_CYC = 256,
  parameter int LOCK_W   = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic locked
);

  localparam logic [LOCK_W-1:0] QMAX = LOCK_W'(LOCK_CYC);

  logic [LOCK_W-1:0] quiet;
  logic [LOCK_W-1:0] quiet_nxt;

  always_comb begin
    quiet_nxt = quiet;
    if (clr) begin
      quiet_nxt = '0;
    end else if (inc && (quiet != QMAX)) begin
      quiet_nxt = quiet + LOCK_W'(1);
    end
  end

  // locked is registered from the next count so it tracks quiet in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quiet  <= '0;
      locked <= 1'b0;
    end else begin
      quiet  <= quiet_nxt;
      locked <= (quiet_nxt == QMAX);
    end
  end

endmodule

// File: rtl/cdr_loop_filter.sv
// Bang-bang PD integrator: turns early/late votes into sl/sr tap commands,
// mirrors the delay-line tap index and flags lock once shifting stops.
module cdr_loop_filter
  import cdr_loop_filter_pkg::*;
#(
  parameter int ACC_W    = 6,
  parameter int THRESH   = DEF_THRESH,
  parameter int HOLDOFF  = DEF_HOLDOFF,
  parameter int LOCK_CYC = DEF_LOCK_CYC,
  parameter int LOCK_W   = DEF_LOCK_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             early,
  input  logic             late,
  output logic             sl,
  output logic             sr,
  output logic [TAP_W-1:0] tap_idx,
  output logic             locked
);

  localparam int HOLD_W = $clog2(HOLDOFF + 1);
  localparam logic signed [ACC_W-1:0] POS_TH = ACC_W'(THRESH);
  localparam logic signed [ACC_W-1:0] NEG_TH = ACC_W'(-THRESH);

  function automatic logic signed [1:0] decode_step(input logic e, input logic l);
    if (e && !l) return 2'sd1;
    if (l && !e) return -2'sd1;
    return 2'sd0;
  endfunction

  function automatic logic [TAP_W-1:0] tap_move(input logic [TAP_W-1:0] tap, input logic up);
    return up ? tap + TAP_W'(1) : tap - TAP_W'(1);
  endfunction

  cdr_state_e              state;
  cdr_state_e              state_nxt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [1:0]       step;
  logic [HOLD_W-1:0]       hold_cnt;
  logic [HOLD_W-1:0]       hold_nxt;
  logic [TAP_W-1:0]        tap_nxt;
  logic                    sl_nxt;
  logic                    sr_nxt;
  logic                    hit;
  logic                    inc;

  assign step    = decode_step(early, late);
  assign acc_sum = acc + ACC_W'(step);

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    hold_nxt  = hold_cnt;
    tap_nxt   = tap_idx;
    sl_nxt    = 1'b0;
    sr_nxt    = 1'b0;
    hit       = 1'b0;
    inc       = 1'b0;
    if (!en) begin
      state_nxt = ST_TRACK;
      acc_nxt   = '0;
      hold_nxt  = '0;
    end else begin
      case (state)
        ST_TRACK: begin
          if ((acc_sum == POS_TH) || (acc_sum == NEG_TH)) begin
            hit       = 1'b1;
            sl_nxt    = (acc_sum == POS_TH);
            sr_nxt    = (acc_sum == NEG_TH);
            tap_nxt   = tap_move(tap_idx, acc_sum == POS_TH);
            acc_nxt   = '0;
            hold_nxt  = HOLD_W'(HOLDOFF - 1);
            state_nxt = ST_HOLD;
          end else begin
            acc_nxt = acc_sum;
            inc     = 1'b1;
          end
        end
        ST_HOLD: begin
          // hold_cnt counts down through the pulse cycle; TRACK resumes after zero
          acc_nxt = '0;
          if (hold_cnt == '0) begin
            state_nxt = ST_TRACK;
          end else begin
            hold_nxt = hold_cnt - HOLD_W'(1);
          end
        end
        default: state_nxt = ST_TRACK;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_TRACK;
      acc      <= '0;
      hold_cnt <= '0;
      tap_idx  <= '0;
      sl       <= 1'b0;
      sr       <= 1'b0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      hold_cnt <= hold_nxt;
      tap_idx  <= tap_nxt;
      sl       <= sl_nxt;
      sr       <= sr_nxt;
    end
  end

  cdr_lock_detect #(
    .LOCK_CYC(LOCK_CYC),
    .LOCK_W  (LOCK_W)
  ) u_lock (
    .clk   (clk),
    .rst   (rst),
    .clr   (hit || !en),
    .inc   (inc),
    .locked(locked)
  );

endmodule

// File: tb/tb_cdr_loop_filter.sv
// Bench for cdr_loop_filter: directed scenarios plus biased random early/late traffic
// compared cycle by cycle against a behavioural loop model.
module tb_cdr_loop_filter;
  import cdr_loop_filter_pkg::*;

  localparam int THRESH   = 8;
  localparam int HOLDOFF  = 16;
  localparam int LOCK_CYC = 256;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       early = 1'b0;
  logic       late = 1'b0;
  logic       sl;
  logic       sr;
  logic [3:0] tap_idx;
  logic       locked;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  int m_acc, m_hold, m_tap, m_quiet, ctrl;
  bit m_sl, m_sr, m_locked;

  always #5 clk = ~clk;

  cdr_loop_filter #(
    .ACC_W   (6),
    .THRESH  (THRESH),
    .HOLDOFF (HOLDOFF),
    .LOCK_CYC(LOCK_CYC),
    .LOCK_W  (9)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .early  (early),
    .late   (late),
    .sl     (sl),
    .sr     (sr),
    .tap_idx(tap_idx),
    .locked (locked)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, $signed(got), $signed(exp), $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_hold = 0; m_tap = 0; m_quiet = 0; ctrl = 0;
    m_sl = 0; m_sr = 0; m_locked = 0;
  endtask

  // One clock of the loop, described as remaining-hold cycles and a plain integer tap.
  task automatic model_step(input bit e, input bit l, input bit g);
    int s;
    int a;
    m_sl = 0;
    m_sr = 0;
    if (!g) begin
      m_acc = 0; m_quiet = 0; m_hold = 0;
    end else if (m_hold > 0) begin
      m_hold--;
    end else begin
      s = (e && !l) ? 1 : ((l && !e) ? -1 : 0);
      a = m_acc + s;
      if (a == THRESH || a == -THRESH) begin
        m_sl    = (a > 0);
        m_sr    = (a < 0);
        m_tap   = (m_tap + ((a > 0) ? 1 : 15)) % 16;
        m_acc   = 0;
        m_hold  = HOLDOFF;
        m_quiet = 0;
      end else begin
        m_acc = a;
        if (m_quiet < LOCK_CYC) m_quiet++;
      end
    end
    m_locked = (m_quiet == LOCK_CYC);
  endtask

  task automatic cyc(input bit e, input bit l, input bit g);
    early = e;
    late  = l;
    en    = g;
    @(posedge clk);
    model_step(e, l, g);
    #1;
    check_eq("sl", sl, m_sl);
    check_eq("sr", sr, m_sr);
    check_eq("tap_idx", tap_idx, m_tap);
    check_eq("locked", locked, m_locked);
    check_eq("acc", int'(dut.acc), m_acc);
    check_eq("sl_sr_excl", sl & sr, 0);
    if (sl) ctrl = (ctrl + 1) % 16;
    if (sr) ctrl = (ctrl + 15) % 16;
    if (sl || sr) check_eq("ctrl_vs_tap", tap_idx, ctrl);
  endtask

  // Called just after an active edge; asserts reset between edges and checks it took hold at once.
  task automatic async_reset();
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_eq("rst_sl", sl, 0);
    check_eq("rst_sr", sr, 0);
    check_eq("rst_tap", tap_idx, 0);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_state", int'(dut.state), int'(ST_TRACK));
    check_eq("rst_acc", int'(dut.acc), 0);
    #1 rst = 1'b0;
  endtask

  initial begin
    int pe;
    int pl;
    model_reset();
    @(posedge clk);
    #1;
    async_reset();

    // shift left after 8 earlies, then hold-off with early still asserted
    repeat (8) cyc(1, 0, 1);
    check_eq("sl_cycle9", sl, 1);
    repeat (16) cyc(1, 0, 1);
    // reset mid-hold while sl is high
    repeat (7) cyc(1, 0, 1);
    cyc(1, 0, 1);
    check_eq("sl_before_rst", sl, 1);
    async_reset();

    // sixteen sr bursts walk the tap all the way round
    for (int b = 0; b < 16; b++) begin
      repeat (8) cyc(0, 1, 1);
      check_eq("wrap_tap", tap_idx, (16 - (b + 1)) % 16);
      repeat (16) cyc(0, 0, 1);
    end

    // ties then alternation never shift
    async_reset();
    repeat (100) cyc(1, 1, 1);
    for (int i = 0; i < 100; i++) cyc(i % 2 == 0, i % 2 == 1, 1);
    check_eq("alt_tap", tap_idx, 0);

    // lock after 256 quiet cycles, lost on an sr pulse
    async_reset();
    repeat (255) cyc(0, 0, 1);
    check_eq("lock_255", locked, 0);
    cyc(0, 0, 1);
    check_eq("lock_256", locked, 1);
    repeat (7) cyc(0, 1, 1);
    cyc(0, 1, 1);
    check_eq("lock_drop_sr", sr, 1);
    check_eq("lock_drop", locked, 0);
    repeat (16) cyc(0, 0, 1);

    // enable drop clears a nearly-full accumulator but keeps the tap
    repeat (7) cyc(1, 0, 1);
    check_eq("en_acc7", int'(dut.acc), 7);
    cyc(0, 0, 0);
    check_eq("en_acc0", int'(dut.acc), 0);
    check_eq("en_tap", tap_idx, 15);
    cyc(1, 0, 1);
    repeat (20) cyc(0, 0, 1);

    // biased random traffic with occasional enable drops and resets
    for (int blk = 0; blk < 24; blk++) begin
      case ($urandom_range(0, 3))
        0: begin pe = 75; pl = 15; end
        1: begin pe = 15; pl = 75; end
        2: begin pe = 50; pl = 50; end
        default: begin pe = 0; pl = 0; end
      endcase
      for (int i = 0; i < 200; i++) begin
        cyc($urandom_range(0, 99) < pe, $urandom_range(0, 99) < pl, $urandom_range(0, 99) < 98);
      end
      if (blk % 8 == 7) async_reset();
    end
    repeat (300) cyc(0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
